score_keeper: RTL and testbench
===============================

# score_keeper

Game-state and scoring stage downstream of the bird/tube playfield. It watches the green tube row that the bird occupies and the `dead` collision flag. It runs the IDLE/PLAY/OVER game state machine and keeps a 3-digit BCD score plus a session high score. It drives the six seven-segment displays HEX0–HEX5, which the top level currently leaves unconnected.

## Interface
Parameters:
- `SAT_SCORE`, default 999: score saturation value (decimal, ≤ 999).

Ports:
- `clk`, input, 1: system clock. The same clock that steps the tube columns.
- `RST`, input, 1: reset. Synchronous, active-high. Clears all state, including the high score.
- `start`, input, 1: single-cycle start/restart pulse. Sourced from a `userIn` edge-pulse on a KEY.
- `dead`, input, 1: collision flag from the `death` block. Level signal.
- `tube_row`, input, 16: `GrnPixels[11]`, the tube column currently in the bird's row.
- `playing`, output, 1: high while state = PLAY.
- `score_bcd`, output, 12: current score as `{hundreds, tens, units}` BCD.
- `hi_bcd`, output, 12: high score as BCD.
- `HEX0`–`HEX2`, output, 7 each: score units/tens/hundreds. Active-low segments.
- `HEX3`–`HEX5`, output, 7 each: high-score units/tens/hundreds. Active-low segments.

## Operation
- State machine:
  - IDLE: `start` moves to PLAY.
  - PLAY: `dead` moves to OVER. `start` is ignored in PLAY.
  - OVER: `start` moves to IDLE and clears the score. `dead` is ignored outside PLAY.
- Occupancy register:
  - `occ_q <= |tube_row` every cycle, in all states.
  - On reset, `occ_q` = 0.
- Pass detection: `pass = (state==PLAY) && occ_q && !(|tube_row) && !dead`. A pass is a tube fully leaving the bird's row.
- Score increment:
  - On `pass`, the BCD score increments by 1, with carry units→tens→hundreds (9 rolls to 0 and carries).
  - At `SAT_SCORE` the score holds; there is no wrap.
- Score clearing:
  - The score is cleared on RST and on the OVER→IDLE transition.
  - It is not cleared on IDLE→PLAY. IDLE therefore always starts at 0.
- High-score update:
  - On the PLAY→OVER transition, if the registered `score_bcd` > `hi_bcd` (BCD compare, equivalent to binary compare), `hi_bcd <= score_bcd`.
  - `hi_bcd` is cleared only by RST.
- Segment encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Blank = 1111111.
- Leading-zero blanking, applied per 3-digit group:
  - The hundreds digit is blank if it is 0.
  - The tens digit is blank if hundreds and tens are both 0.
  - The units digit is always shown.
- Combinational rules: the HEX outputs are combinational decodes of the registered BCD values. No other combinational path exists from the inputs to the outputs.

## Timing
- Reset values (cycle after RST is sampled high):
  - State IDLE, `playing`=0, `occ_q`=0.
  - `score_bcd` = 0, `hi_bcd` = 0.
  - HEX0 = HEX3 = 1000000; HEX1, HEX2, HEX4, HEX5 = 1111111.
- Mid-operation reset: RST overrides every other input in the same cycle.
- `start` latency: `start` sampled high in IDLE gives `playing`=1 on the next edge.
- `dead` latency: `dead` sampled high in PLAY gives `playing`=0 and the state OVER on the next edge. `hi_bcd` updates on that same edge, using the score value before the edge.
- Pass latency: `score_bcd` increments on the edge where `pass` is evaluated true. That is one cycle after `tube_row` goes to zero, because `occ_q` holds the previous cycle's occupancy.
- Simultaneous events:
  - `pass` and `dead` in the same cycle: no increment; go to OVER.
  - `start` and `dead` in IDLE: go to PLAY only.
- At most one increment per occupied→empty transition. A tube that stays in the row for several cycles counts once.
- Entering PLAY while `occ_q`=1 and the row then empties: this counts as a pass (accepted behaviour).

## Test plan
- Reset: RST=1 for one cycle → `score_bcd`=000, `hi_bcd`=000, `playing`=0, HEX0=1000000, HEX1=1111111, HEX2=1111111.
- Single pass: `start` pulse; `tube_row`=16'hF0FF for 3 cycles, then 16'h0000 → `score_bcd`=001 exactly one cycle after the row empties, and it stays 001 while the row stays empty.
- BCD carry and blanking: drive 10 passes → `score_bcd`=12'h010, HEX1=1111001, HEX0=1000000, HEX2=1111111. Force 999, then one more pass → remains 12'h999.
- Death and high score: score 005, then `dead`=1 → OVER, `hi_bcd`=005 next cycle. `start` → IDLE, score 000. New game reaching 003 then dying → `hi_bcd` stays 005.
- Simultaneous pass and dead: with `occ_q`=1, drive `tube_row`=0 and `dead`=1 in the same cycle → score unchanged, state OVER. Extra `start` pulses in PLAY are ignored.
- Mid-game reset: in PLAY with score 042 and `hi_bcd` 050, assert RST → all outputs return to reset values, including `hi_bcd`=000.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: flappy game state machine, saturating BCD score, session high score and HEX display drive
module score_keeper #(
  parameter int SAT_SCORE = 999
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        start,
  input  logic        dead,
  input  logic [15:0] tube_row,
  output logic        playing,
  output logic [11:0] score_bcd,
  output logic [11:0] hi_bcd,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [11:0] SAT_BCD = {4'(SAT_SCORE / 100), 4'(SAT_SCORE / 10 % 10), 4'(SAT_SCORE % 10)};
  localparam logic [6:0] BLANK = 7'b1111111;
  state_t state, state_n;
  logic occ_q, pass;
  logic [11:0] score_n, hi_n;
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    bcd_inc = v[3:0] != 4'd9 ? {v[11:4], v[3:0] + 4'd1} :
              v[7:4] != 4'd9 ? {v[11:8], v[7:4] + 4'd1, 4'd0} :
                               {v[11:8] + 4'd1, 8'd0};
  endfunction
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = BLANK;
    endcase
  endfunction
  // a pass is the registered-occupied row becoming empty while alive
  assign pass = state == PLAY && occ_q && !(|tube_row) && !dead;
  always_comb begin
    state_n = (state == IDLE && start) ? PLAY :
              (state == PLAY && dead)  ? OVER :
              (state == OVER && start) ? IDLE : state;
    score_n = (state == OVER && start) ? 12'd0 :
              (pass && score_bcd != SAT_BCD) ? bcd_inc(score_bcd) : score_bcd;
    hi_n = (state == PLAY && dead && score_bcd > hi_bcd) ? score_bcd : hi_bcd;
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      occ_q     <= 1'b0;
      score_bcd <= 12'd0;
      hi_bcd    <= 12'd0;
    end else begin
      state     <= state_n;
      occ_q     <= |tube_row;
      score_bcd <= score_n;
      hi_bcd    <= hi_n;
    end
  end
  assign playing = state == PLAY;
  assign HEX0 = seg(score_bcd[3:0]);
  assign HEX1 = score_bcd[11:4] == 8'd0 ? BLANK : seg(score_bcd[7:4]);
  assign HEX2 = score_bcd[11:8] == 4'd0 ? BLANK : seg(score_bcd[11:8]);
  assign HEX3 = seg(hi_bcd[3:0]);
  assign HEX4 = hi_bcd[11:4] == 8'd0 ? BLANK : seg(hi_bcd[7:4]);
  assign HEX5 = hi_bcd[11:8] == 4'd0 ? BLANK : seg(hi_bcd[11:8]);
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: table-driven vectors plus hand sequences for carry, saturation and mid-game reset
module tb_score_keeper;
  logic clk = 1'b0;
  logic RST = 1'b1, start = 1'b0, dead = 1'b0;
  logic [15:0] tube_row = 16'h0;
  logic playing;
  logic [11:0] score_bcd, hi_bcd;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int total = 0, passed = 0;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D4 = 7'b0011001,
                         D5 = 7'b0010010, D9 = 7'b0010000, BL = 7'b1111111;
  typedef struct {
    logic rst, st, dd;
    logic [15:0] row;
    logic play;
    logic [11:0] sc, hi;
  } vec_t;
  vec_t v [32];
  score_keeper dut (
    .clk(clk), .RST(RST), .start(start), .dead(dead), .tube_row(tube_row),
    .playing(playing), .score_bcd(score_bcd), .hi_bcd(hi_bcd),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_pass();
    tube_row = 16'h0001;
    tick();
    tube_row = 16'h0000;
    tick();
  endtask
  task automatic chk_hex(input string name, input logic [6:0] h2, h1, h0, h5, h4, h3);
    chk({name, "_hex2"}, 32'(HEX2), 32'(h2));
    chk({name, "_hex1"}, 32'(HEX1), 32'(h1));
    chk({name, "_hex0"}, 32'(HEX0), 32'(h0));
    chk({name, "_hex5"}, 32'(HEX5), 32'(h5));
    chk({name, "_hex4"}, 32'(HEX4), 32'(h4));
    chk({name, "_hex3"}, 32'(HEX3), 32'(h3));
  endtask
  task automatic chk_state(input string name, input logic p, input logic [11:0] s, h);
    chk({name, "_playing"}, 32'(playing), 32'(p));
    chk({name, "_score"}, 32'(score_bcd), 32'(s));
    chk({name, "_hi"}, 32'(hi_bcd), 32'(h));
  endtask
  task automatic do_reset();
    RST = 1'b1; start = 1'b0; dead = 1'b0; tube_row = 16'h0;
    tick();
    RST = 1'b0;
  endtask
  initial begin
    v = '{
      '{1, 0, 0, 16'h0000, 0, 12'h000, 12'h000},
      '{0, 1, 0, 16'h0000, 1, 12'h000, 12'h000},
      '{0, 0, 0, 16'hF0FF, 1, 12'h000, 12'h000},
      '{0, 0, 0, 16'hF0FF, 1, 12'h000, 12'h000},
      '{0, 0, 0, 16'hF0FF, 1, 12'h000, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h001, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h001, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h001, 12'h000},
      '{0, 0, 0, 16'h0001, 1, 12'h001, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h002, 12'h000},
      '{0, 0, 0, 16'h8000, 1, 12'h002, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h003, 12'h000},
      '{0, 0, 0, 16'h0100, 1, 12'h003, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h004, 12'h000},
      '{0, 0, 0, 16'h0010, 1, 12'h004, 12'h000},
      '{0, 0, 0, 16'h0000, 1, 12'h005, 12'h000},
      '{0, 0, 1, 16'h0000, 0, 12'h005, 12'h005},
      '{0, 1, 0, 16'h0000, 0, 12'h000, 12'h005},
      '{0, 1, 0, 16'h0000, 1, 12'h000, 12'h005},
      '{0, 0, 0, 16'h0001, 1, 12'h000, 12'h005},
      '{0, 0, 0, 16'h0000, 1, 12'h001, 12'h005},
      '{0, 0, 0, 16'h0001, 1, 12'h001, 12'h005},
      '{0, 0, 0, 16'h0000, 1, 12'h002, 12'h005},
      '{0, 0, 0, 16'h0001, 1, 12'h002, 12'h005},
      '{0, 0, 0, 16'h0000, 1, 12'h003, 12'h005},
      '{0, 1, 0, 16'h0001, 1, 12'h003, 12'h005},
      '{0, 0, 1, 16'h0000, 0, 12'h003, 12'h005},
      '{0, 0, 1, 16'h0000, 0, 12'h003, 12'h005},
      '{0, 1, 1, 16'h0000, 0, 12'h000, 12'h005},
      '{0, 1, 1, 16'h0000, 1, 12'h000, 12'h005},
      '{0, 0, 0, 16'h0001, 1, 12'h000, 12'h005},
      '{0, 0, 0, 16'h0000, 1, 12'h001, 12'h005}
    };
    for (int i = 0; i < 32; i++) begin
      RST = v[i].rst; start = v[i].st; dead = v[i].dd; tube_row = v[i].row;
      tick();
      chk_state($sformatf("v%0d", i), v[i].play, v[i].sc, v[i].hi);
      if (i == 0) chk_hex("v0_reset", BL, BL, D0, BL, BL, D0);
      if (i == 16) chk_hex("v16_hi5", BL, BL, D5, BL, BL, D5);
    end
    do_reset();
    chk_state("reset2", 1'b0, 12'h000, 12'h000);
    chk_hex("reset2", BL, BL, D0, BL, BL, D0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) do_pass();
    chk_state("carry10", 1'b1, 12'h010, 12'h000);
    chk_hex("carry10", BL, D1, D0, BL, BL, D0);
    for (int i = 0; i < 90; i++) do_pass();
    chk_state("carry100", 1'b1, 12'h100, 12'h000);
    chk_hex("carry100", D1, D0, D0, BL, BL, D0);
    for (int i = 0; i < 899; i++) do_pass();
    chk_state("sat999", 1'b1, 12'h999, 12'h000);
    chk_hex("sat999", D9, D9, D9, BL, BL, D0);
    do_pass();
    chk_state("sat_hold", 1'b1, 12'h999, 12'h000);
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 50; i++) do_pass();
    dead = 1'b1; tick(); dead = 1'b0;
    chk_state("hi50", 1'b0, 12'h050, 12'h050);
    start = 1'b1; tick(); tick(); start = 1'b0;
    chk_state("replay", 1'b1, 12'h000, 12'h050);
    for (int i = 0; i < 42; i++) do_pass();
    chk_state("mid42", 1'b1, 12'h042, 12'h050);
    chk_hex("mid42", BL, D4, D2, BL, D5, D0);
    tube_row = 16'hFFFF; start = 1'b1; dead = 1'b1; RST = 1'b1;
    tick();
    RST = 1'b0; start = 1'b0; dead = 1'b0; tube_row = 16'h0000;
    chk_state("midrst", 1'b0, 12'h000, 12'h000);
    chk_hex("midrst", BL, BL, D0, BL, BL, D0);
    tick();
    chk_state("midrst_occ0", 1'b0, 12'h000, 12'h000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
